// File: rtl/axi_master_fsm.sv
// axi_master_fsm
//   Single-beat AXI-lite style initiator for the byte-memory slave. One read or
//   write command is accepted at a time from local logic. The block runs the
//   AW/W/B or AR/R handshakes and reports completion with a one-cycle rsp_done
//   pulse and an error flag.
//
// Ports
//   M_ACLK, M_ARRESET_N            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready            command handshake; cmd_ready is high only in IDLE
//   cmd_write/addr/wdata/strb      command payload; strb is used as WSTRB on
//                                  writes and as the byte-lane enables on reads
//   rsp_done/rsp_err/rsp_rdata     completion pulse, error flag, read data
//   M_AW*/S_AWREADY, M_W*/S_WREADY write address and write data channels
//   M_BREADY/S_BRESP/S_BVALID      write response channel
//   M_AR*/S_ARREADY                read address channel
//   M_RREADY/M_BLEN/S_RVALID/S_RDATA read data channel and byte-lane enables
//
// Every output is a flop, so there is no combinational path from S_* to M_*.
module axi_master_fsm #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              M_ACLK,
  input  logic              M_ARRESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_done,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              M_AWVALID,
  output logic [ADDR_W-1:0] M_AWADDR,
  input  logic              S_AWREADY,
  output logic              M_WVALID,
  output logic [31:0]       M_WDATA,
  output logic [3:0]        M_WSTRB,
  input  logic              S_WREADY,
  output logic              M_BREADY,
  input  logic [1:0]        S_BRESP,
  input  logic              S_BVALID,
  output logic              M_ARVALID,
  output logic [ADDR_W-1:0] M_ARADDR,
  input  logic              S_ARREADY,
  output logic              M_RREADY,
  output logic [3:0]        M_BLEN,
  input  logic              S_RVALID,
  input  logic [31:0]       S_RDATA
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // Abort fires on the last of TIMEOUT waiting cycles, so a stalled VALID is
  // held for exactly TIMEOUT cycles.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             aw_left;
  logic             w_left;
  logic [31:0]      rdata_masked;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  // A channel is still outstanding if its VALID is up and this edge is not its transfer.
  assign aw_left = M_AWVALID & ~S_AWREADY;
  assign w_left  = M_WVALID  & ~S_WREADY;

  always_comb begin
    rdata_masked = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      rdata_masked[8*i +: 8] = M_BLEN[i] ? S_RDATA[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge M_ACLK or negedge M_ARRESET_N) begin
    if (!M_ARRESET_N) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      cmd_ready <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      M_AWVALID <= 1'b0;
      M_AWADDR  <= '0;
      M_WVALID  <= 1'b0;
      M_WDATA   <= '0;
      M_WSTRB   <= '0;
      M_BREADY  <= 1'b0;
      M_ARVALID <= 1'b0;
      M_ARADDR  <= '0;
      M_RREADY  <= 1'b0;
      M_BLEN    <= '0;
    end else begin
      rsp_done <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          tmo_cnt   <= '0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              M_AWADDR  <= cmd_addr;
              M_WDATA   <= cmd_wdata;
              M_WSTRB   <= cmd_strb;
              M_AWVALID <= 1'b1;
              M_WVALID  <= 1'b1;
              state     <= WADDR;
            end else begin
              M_ARADDR  <= cmd_addr;
              M_BLEN    <= cmd_strb;
              M_ARVALID <= 1'b1;
              state     <= RADDR;
            end
          end
        end

        WADDR: begin
          if (S_AWREADY) M_AWVALID <= 1'b0;
          if (S_WREADY)  M_WVALID  <= 1'b0;
          if (!aw_left && !w_left) begin
            M_BREADY <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WRESP;
          end else if (tmo_hit) begin
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_done  <= 1'b1;
            tmo_cnt   <= '0;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        WRESP: begin
          if (S_BVALID) begin
            M_BREADY <= 1'b0;
            rsp_err  <= |S_BRESP;
            rsp_done <= 1'b1;
            tmo_cnt  <= '0;
            state    <= DONE;
          end else if (tmo_hit) begin
            M_BREADY <= 1'b0;
            rsp_err  <= 1'b1;
            rsp_done <= 1'b1;
            tmo_cnt  <= '0;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        RADDR: begin
          // An early S_RVALID is deliberately ignored here; R is taken only in RDATA.
          if (S_ARREADY) begin
            M_ARVALID <= 1'b0;
            M_RREADY  <= 1'b1;
            tmo_cnt   <= '0;
            state     <= RDATA;
          end else if (tmo_hit) begin
            M_ARVALID <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_done  <= 1'b1;
            tmo_cnt   <= '0;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        RDATA: begin
          if (S_RVALID) begin
            M_RREADY  <= 1'b0;
            rsp_rdata <= rdata_masked;
            rsp_err   <= 1'b0;
            rsp_done  <= 1'b1;
            tmo_cnt   <= '0;
            state     <= DONE;
          end else if (tmo_hit) begin
            M_RREADY <= 1'b0;
            rsp_err  <= 1'b1;
            rsp_done <= 1'b1;
            tmo_cnt  <= '0;
            state    <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end

        DONE: begin
          rsp_err   <= 1'b0;
          cmd_ready <= 1'b1;
          tmo_cnt   <= '0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_master_fsm.sv
// Testbench for axi_master_fsm: a behavioural byte-memory slave with
// configurable wait states / stalls / BRESP, a word-level reference memory that
// predicts each response, and a scoreboard popped by a monitor on rsp_done.
module tb_axi_master_fsm;
  localparam int unsigned AW  = 32;
  localparam int          TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic          rsp_done, rsp_err;
  logic [31:0]   rsp_rdata;
  logic          M_AWVALID, S_AWREADY, M_WVALID, S_WREADY, M_BREADY, S_BVALID;
  logic [AW-1:0] M_AWADDR, M_ARADDR;
  logic [31:0]   M_WDATA, S_RDATA;
  logic [3:0]    M_WSTRB, M_BLEN;
  logic [1:0]    S_BRESP;
  logic          M_ARVALID, S_ARREADY, M_RREADY, S_RVALID;

  always #5 clk = ~clk;

  axi_master_fsm #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .M_ACLK(clk), .M_ARRESET_N(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .M_AWVALID(M_AWVALID), .M_AWADDR(M_AWADDR), .S_AWREADY(S_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .S_WREADY(S_WREADY),
    .M_BREADY(M_BREADY), .S_BRESP(S_BRESP), .S_BVALID(S_BVALID),
    .M_ARVALID(M_ARVALID), .M_ARADDR(M_ARADDR), .S_ARREADY(S_ARREADY),
    .M_RREADY(M_RREADY), .M_BLEN(M_BLEN), .S_RVALID(S_RVALID), .S_RDATA(S_RDATA)
  );

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0, cmd_id = 0;
  bit chk_ready_next = 0;

  // slave configuration for the command in flight
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0, cfg_stall = 0;
  logic [1:0] cfg_bresp = 2'b00;

  logic [31:0] rmem [16];
  logic [31:0] last_rdata;

  // edge-sampled handshakes, captured payloads, cycle bookkeeping
  logic hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
  logic [AW-1:0] aw_addr_q = '0, ar_addr_q = '0;
  logic [31:0] wdata_q = '0;
  logic [3:0]  wstrb_q = '0;
  int cyc = 0, acc_cyc_q = 0, aw_hi = 0, w_hi = 0, ar_hi = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    hs_aw <= M_AWVALID & S_AWREADY;
    hs_w  <= M_WVALID & S_WREADY;
    hs_b  <= M_BREADY & S_BVALID;
    hs_ar <= M_ARVALID & S_ARREADY;
    hs_r  <= M_RREADY & S_RVALID;
    if (M_AWVALID && S_AWREADY) aw_addr_q <= M_AWADDR;
    if (M_WVALID && S_WREADY) begin wdata_q <= M_WDATA; wstrb_q <= M_WSTRB; end
    if (M_ARVALID && S_ARREADY) ar_addr_q <= M_ARADDR;
    if (cmd_valid && cmd_ready) begin
      acc_cyc_q <= cyc;
      aw_hi <= 0; w_hi <= 0; ar_hi <= 0;
    end else begin
      aw_hi <= aw_hi + int'(M_AWVALID);
      w_hi  <= w_hi + int'(M_WVALID);
      ar_hi <= ar_hi + int'(M_ARVALID);
    end
  end

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
  endtask

  // Behavioural slave: ready/valid raised after cfg_* cycles, never if stalled.
  initial begin
    logic [31:0] smem [16];
    bit aw_got, w_got, b_pend, ar_got;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_BRESP = 2'b00;
    S_ARREADY = 0; S_RVALID = 0; S_RDATA = '0;
    for (int i = 0; i < 16; i++) smem[i] = '0;
    aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n || rsp_done) begin
        S_AWREADY = 0; S_WREADY = 0; S_BVALID = 0; S_BRESP = 2'b00;
        S_ARREADY = 0; S_RVALID = 0; S_RDATA = '0;
        aw_got = 0; w_got = 0; b_pend = 0; ar_got = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (hs_aw) begin S_AWREADY = 0; aw_got = 1; end
        else if (M_AWVALID && !aw_got && !S_AWREADY) begin
          if (aw_cnt >= cfg_aw && cfg_stall != 1) S_AWREADY = 1; else aw_cnt++;
        end
        if (hs_w) begin S_WREADY = 0; w_got = 1; end
        else if (M_WVALID && !w_got && !S_WREADY) begin
          if (w_cnt >= cfg_w && cfg_stall != 2) S_WREADY = 1; else w_cnt++;
        end
        if (aw_got && w_got && !b_pend) begin
          for (int i = 0; i < 4; i++)
            if (wstrb_q[i]) smem[aw_addr_q[5:2]][8*i +: 8] = wdata_q[8*i +: 8];
          b_pend = 1;
        end
        if (hs_b) begin S_BVALID = 0; S_BRESP = 2'b00; end
        else if (b_pend && !S_BVALID) begin
          if (b_cnt >= cfg_b && cfg_stall != 3) begin S_BVALID = 1; S_BRESP = cfg_bresp; end
          else b_cnt++;
        end
        if (hs_ar) begin S_ARREADY = 0; ar_got = 1; end
        else if (M_ARVALID && !ar_got && !S_ARREADY) begin
          if (ar_cnt >= cfg_ar && cfg_stall != 4) S_ARREADY = 1; else ar_cnt++;
        end
        if (hs_r) S_RVALID = 0;
        else if (ar_got && !S_RVALID) begin
          if (r_cnt >= cfg_r && cfg_stall != 5) begin
            S_RVALID = 1; S_RDATA = smem[ar_addr_q[5:2]];
          end else r_cnt++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every rsp_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_ready_next) begin
        chk_ready_next = 0;
        check32("cmd_ready_after_done", {31'b0, cmd_ready}, 32'd1);
      end
      if (rsp_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: rsp_done=1 required 0 (nothing outstanding)");
        end else begin
          e = sb.pop_front();
          check32($sformatf("rsp_err[%0d]", e.id), {31'b0, rsp_err}, {31'b0, e.err});
          check32($sformatf("rsp_rdata[%0d]", e.id), rsp_rdata, e.rdata);
          check32($sformatf("latency[%0d]", e.id), 32'(cyc - acc_cyc_q + 1), 32'(e.lat));
          chk_ready_next = 1;
        end
      end
    end
  end

  // Reference: latency = accept cycle + cycles in each wait state + DONE cycle.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input int awd, input int wd, input int bd,
                         input int ard, input int rd, input int stl, input logic [1:0] br);
    exp_t e;
    int waited, start, m;
    e.id = cmd_id++;
    m = (awd > wd) ? awd : wd;
    if (wr) begin
      if (stl == 1 || stl == 2) begin
        e.lat = TMO + 2; e.err = 1;
      end else begin
        for (int i = 0; i < 4; i++)
          if (strb[i]) rmem[addr[5:2]][8*i +: 8] = data[8*i +: 8];
        if (stl == 3) begin e.lat = m + TMO + 3; e.err = 1; end
        else begin e.lat = m + bd + 4; e.err = (br != 2'b00); end
      end
    end else begin
      if (stl == 4) begin e.lat = TMO + 2; e.err = 1; end
      else if (stl == 5) begin e.lat = ard + TMO + 3; e.err = 1; end
      else begin
        e.lat = ard + rd + 4; e.err = 0;
        for (int i = 0; i < 4; i++)
          last_rdata[8*i +: 8] = strb[i] ? rmem[addr[5:2]][8*i +: 8] : 8'h00;
      end
    end
    e.rdata = last_rdata;
    cfg_aw = awd; cfg_w = wd; cfg_b = bd; cfg_ar = ard; cfg_r = rd;
    cfg_stall = stl; cfg_bresp = br;
    @(negedge clk);
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_strb = strb; cmd_valid = 1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
    if (!cmd_ready) begin
      total_cnt++;
      $display("FAIL accept_timeout[%0d]: cmd_ready=0 required 1", e.id);
      cmd_valid = 0;
      return;
    end
    start = done_cnt;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid = 0;
    waited = 0;
    while (done_cnt == start && waited < 60) begin @(negedge clk); waited++; end
    if (done_cnt == start) begin
      total_cnt++;
      $display("FAIL done_timeout[%0d]: no rsp_done required one", e.id);
      void'(sb.pop_front());
    end
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_valid_ready"},
            {24'b0, M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, cmd_ready, rsp_done, rsp_err},
            32'd0);
    check32({tag, "_awaddr"}, M_AWADDR, 32'd0);
    check32({tag, "_araddr"}, M_ARADDR, 32'd0);
    check32({tag, "_wdata"}, M_WDATA, 32'd0);
    check32({tag, "_strb_blen"}, {24'b0, M_WSTRB, M_BLEN}, 32'd0);
    check32({tag, "_rdata"}, rsp_rdata, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited, start, r, stl;
    bit wr;
    for (int i = 0; i < 16; i++) rmem[i] = '0;
    last_rdata = '0;
    #23;
    check_all_zero("reset");
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    check32("cmd_ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // 1: zero-wait write
    run_cmd(1, 32'h04, 32'hA1B2C3D4, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);
    // 2: masked read-back
    run_cmd(0, 32'h04, 32'h0, 4'b0101, 0, 0, 0, 0, 0, 0, 2'b00);
    // 3: W ready three cycles after AW ready
    run_cmd(1, 32'h08, 32'h55AA55AA, 4'hF, 0, 3, 0, 0, 0, 0, 2'b00);
    check32("t3_awvalid_cycles", 32'(aw_hi), 32'd1);
    check32("t3_wvalid_cycles", 32'(w_hi), 32'd4);
    // 4: error response
    run_cmd(1, 32'h0C, 32'h01020304, 4'hF, 0, 0, 0, 0, 0, 0, 2'b10);
    // 5: AR never accepted
    run_cmd(0, 32'h04, 32'h0, 4'hF, 0, 0, 0, 0, 0, 4, 2'b00);
    check32("t5_arvalid_cycles", 32'(ar_hi), 32'(TMO));

    // 6: reset while waiting in WRESP
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_stall = 3; cfg_bresp = 2'b00;
    @(negedge clk);
    cmd_write = 1; cmd_addr = 32'h20; cmd_wdata = 32'h11223344; cmd_strb = 4'b0011; cmd_valid = 1;
    waited = 0;
    while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
    @(negedge clk); cmd_valid = 0;
    waited = 0;
    while (!M_BREADY && waited < 20) begin @(negedge clk); waited++; end
    check32("t6_reached_wresp", {31'b0, M_BREADY}, 32'd1);
    rmem[8][15:0] = 16'h3344;
    start = done_cnt;
    #2 rst_n = 0;
    #1 check_all_zero("t6_reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    check32("t6_no_done", 32'(done_cnt), 32'(start));
    run_cmd(0, 32'h20, 32'h0, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (wr) stl = (r == 0) ? 1 : (r == 1) ? 2 : (r == 2) ? 3 : 0;
      else    stl = (r == 0) ? 4 : (r == 1) ? 5 : 0;
      run_cmd(wr, {26'b0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), stl,
              ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
